// File: rtl/gr_pkg.sv
// rtl/gr_pkg.sv - shared coordinate/triangle typedefs and read FSM state enum
package gr_pkg;

    localparam int WI = 8;
    localparam int WF = 8;
    localparam int CW = WI + WF;

    typedef logic [CW-1:0]      coord_t;
    typedef coord_t [2:0]       vertex_t;
    typedef vertex_t [2:0]      triangle_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PRESENT,
        ST_DONE
    } rd_state_t;

endpackage

// File: rtl/list_reader_if.sv
// rtl/list_reader_if.sv - triangle stream from list_reader to the transform/raster pipeline
interface list_reader_if #(
    parameter int WI = 8,
    parameter int WF = 8
);

    logic [2:0][2:0][WI+WF-1:0] tri_out;
    logic                       tri_valid;
    logic                       tri_ready;

    modport master (
        output tri_out,
        output tri_valid,
        input  tri_ready
    );

    modport slave (
        input  tri_out,
        input  tri_valid,
        output tri_ready
    );

endinterface

// File: rtl/tri_store.sv
// rtl/tri_store.sv - DEPTH-entry triangle register array with write count
module tri_store #(
    parameter int WI    = 8,
    parameter int WF    = 8,
    parameter int DEPTH = 16
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         wr_en,
    input  logic                         clear,
    input  logic [2:0][2:0][WI+WF-1:0]   wr_data,
    input  logic [$clog2(DEPTH)-1:0]     rd_idx,
    output logic [2:0][2:0][WI+WF-1:0]   rd_data,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [2:0][2:0][WI+WF-1:0] mem [DEPTH];
    logic                       do_write;

    assign full     = (count == DEPTH_C);
    // clear wins over a same-cycle write; a full list drops the write
    assign do_write = wr_en && !clear && !full;
    assign rd_data  = mem[rd_idx];

    // Write count: the next free slot is always mem[count]
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (do_write) begin
            count <= count + 1'b1;
        end
    end

    // Array contents carry no reset; only count decides what is valid
    always_ff @(posedge Clk) begin
        if (do_write && !Reset) begin
            mem[count[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/list_reader.sv
// rtl/list_reader.sv - stores loader triangles and replays them each frame; LIST_OVF_EN adds list_ovf
module list_reader
    import gr_pkg::*;
#(
    parameter int WI    = 8,
    parameter int WF    = 8,
    parameter int DEPTH = 16
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         list_w,
    input  logic [2:0][2:0][WI+WF-1:0]   orig_triangle_in,
    input  logic                         load_done,
    input  logic                         clear_list,
    input  logic                         start_frame,
    list_reader_if.master                tri_if,
    output logic                         frame_done,
    output logic                         list_loaded,
    output logic [$clog2(DEPTH):0]       list_count
`ifdef LIST_OVF_EN
    ,
    output logic                         list_ovf
`endif
);

    localparam int AW = $clog2(DEPTH);

    rd_state_t                  state_q, state_d;
    logic [AW-1:0]              rd_idx_q, rd_idx_d;
    logic [AW:0]                snap_q, snap_d;
    logic [AW:0]                snap_last;
    logic [2:0][2:0][WI+WF-1:0] tri_q, tri_d;
    logic [2:0][2:0][WI+WF-1:0] rd_data;
    logic                       clear_eff;
    logic                       full;

    // A clear arriving mid-pass is ignored so the pass completes on a stable list
    assign clear_eff = clear_list && (state_q == ST_IDLE);
    assign snap_last = snap_q - {{AW{1'b0}}, 1'b1};

    tri_store #(
        .WI    (WI),
        .WF    (WF),
        .DEPTH (DEPTH)
    ) u_store (
        .Clk     (Clk),
        .Reset   (Reset),
        .wr_en   (list_w),
        .clear   (clear_eff),
        .wr_data (orig_triangle_in),
        .rd_idx  (rd_idx_q),
        .rd_data (rd_data),
        .count   (list_count),
        .full    (full)
    );

    assign tri_if.tri_out   = tri_q;
    assign tri_if.tri_valid = (state_q == ST_PRESENT);
    assign frame_done       = (state_q == ST_DONE);

    // Sticky loaded flag, cleared together with the list
    always_ff @(posedge Clk) begin
        if (Reset) begin
            list_loaded <= 1'b0;
        end else if (clear_eff) begin
            list_loaded <= 1'b0;
        end else if (load_done) begin
            list_loaded <= 1'b1;
        end
    end

`ifdef LIST_OVF_EN
    // Sticky overflow flag: a write was dropped because the list was full
    always_ff @(posedge Clk) begin
        if (Reset) begin
            list_ovf <= 1'b0;
        end else if (clear_eff) begin
            list_ovf <= 1'b0;
        end else if (list_w && full) begin
            list_ovf <= 1'b1;
        end
    end
`endif

    // Read FSM state, index, snapshot and output register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            rd_idx_q <= '0;
            snap_q   <= '0;
            tri_q    <= '0;
        end else begin
            state_q  <= state_d;
            rd_idx_q <= rd_idx_d;
            snap_q   <= snap_d;
            tri_q    <= tri_d;
        end
    end

    // Next-state: snapshot the count at start so writes during a pass land beyond it
    always_comb begin
        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        snap_d   = snap_q;
        tri_d    = tri_q;
        case (state_q)
            ST_IDLE: begin
                if (start_frame && list_loaded) begin
                    snap_d   = list_count;
                    rd_idx_d = '0;
                    state_d  = (list_count != '0) ? ST_FETCH : ST_DONE;
                end
            end
            ST_FETCH: begin
                tri_d   = rd_data;
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (tri_if.tri_ready) begin
                    if ({1'b0, rd_idx_q} == snap_last) begin
                        state_d = ST_DONE;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                        state_d  = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
